// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the 5-stage MIPS pipeline.
// Control levels are named so the datapath code reads in pipeline terms.
package regfile_pkg;

    localparam int RegBusWidth     = 32;
    localparam int RegAddrBusWidth = 5;
    localparam int RegNum          = 32;
    localparam int RegNumLog2      = 5;

    localparam logic [RegBusWidth-1:0]     ZeroWord = '0;
    localparam logic [RegAddrBusWidth-1:0] ZeroAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    // Reset is active-low for this block.
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    typedef logic [RegBusWidth-1:0]     reg_word_t;
    typedef logic [RegAddrBusWidth-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset/enable/$0 zeroing, then WB->ID
// forwarding ahead of the stored value.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W = RegBusWidth,
    parameter int ADDR_W = RegAddrBusWidth
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rdata
);

    logic port_active;
    logic fwd_hit;

    // An unknown enable leaves the condition false, so the port stays at zero.
    always_comb begin
        port_active = 1'b0;
        if ((rst == RstDisable) && (re == ReadEnable) && (raddr != '0)) begin
            port_active = 1'b1;
        end
    end

    always_comb begin
        fwd_hit = 1'b0;
        if ((we == WriteEnable) && (waddr == raddr)) begin
            fwd_hit = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (port_active) begin
            if (fwd_hit) begin
                rdata = wdata;
            end else begin
                rdata = stored;
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit MIPS general-purpose register file: one synchronous write
// port, two combinational read ports with write-to-read forwarding.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RegBusWidth,
    parameter int ADDR_W   = RegAddrBusWidth,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // Entry 0 has no storage at all; the read ports supply its zero.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we == WriteEnable) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        stored1 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                stored1 = regs[i];
            end
        end
    end

    always_comb begin
        stored2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr2 == ADDR_W'(i)) begin
                stored2 = regs[i];
            end
        end
    end

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport1 (
        .rst    (rst),
        .re     (re1),
        .raddr  (raddr1),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .stored (stored1),
        .rdata  (rdata1)
    );

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport2 (
        .rst    (rst),
        .re     (re2),
        .raddr  (raddr2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .stored (stored2),
        .rdata  (rdata2)
    );

endmodule
